// File: rtl/seq_det_pkg.sv
// Shared types and transition function for the "1101" sequencing controller
// and its embedded Moore detector.
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } ctrl_state_e;

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } det_state_e;

   localparam logic [3:0] PATTERN = 4'b1101;

   // Overlapping Moore transitions; each state's "advance" bit is taken from PATTERN.
   function automatic det_state_e det_next(input det_state_e s, input logic x);
      det_state_e n;
      n = S0;
      case (s)
         S0:      n = (x == PATTERN[3]) ? S1 : S0;
         S1:      n = (x == PATTERN[2]) ? S2 : S0;
         S2:      n = (x == PATTERN[1]) ? S3 : S2;
         S3:      n = (x == PATTERN[0]) ? S4 : S0;
         S4:      n = x ? S2 : S0;
         default: n = S0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Word-level handshake and debug bundle between a word producer and seq_det_ctrl.
interface seq_det_ctrl_if #(
   parameter int WORD_W = 16,
   parameter int CNT_W  = 5
);
   logic              start;
   logic [WORD_W-1:0] din;
   logic              keep;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  hit_cnt;
   logic              x;
   logic              z;
   logic [2:0]        det_state;

   modport master (
      output start, din, keep,
      input  busy, done, hit_cnt, x, z, det_state
   );

   modport slave (
      input  start, din, keep,
      output busy, done, hit_cnt, x, z, det_state
   );
endinterface

// File: rtl/seq_det_ctrl_det1101_core.sv
// Bit-serial overlapping "1101" Moore detector; clr wins over en.
module det1101_core
   import seq_det_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       clr,
   input  logic       x,
   output logic       z,
   output logic [2:0] state
);

   det_state_e r_state;
   det_state_e w_nxt;

   always_comb begin
      w_nxt = r_state;
      if (clr)
         w_nxt = S0;
      else if (en)
         w_nxt = det_next(r_state, x);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= S0;
      else
         r_state <= w_nxt;
   end

   assign z     = (r_state == S4);
   assign state = r_state;

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-to-serial sequencer: shifts a latched word MSB-first into det1101_core
// and counts hits, reporting the total with a one-cycle done pulse.
module seq_det_ctrl
   import seq_det_pkg::*;
#(
   parameter int WORD_W = 16,
   parameter int CNT_W  = 5
) (
   input  logic          clk,
   input  logic          reset,
   seq_det_ctrl_if.slave bus
);

   localparam int                IDX_W    = $clog2(WORD_W);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_W - 1);

   ctrl_state_e       r_state;
   ctrl_state_e       w_nxt;
   logic [WORD_W-1:0] r_shreg;
   logic [IDX_W-1:0]  r_idx;
   logic [CNT_W-1:0]  r_cnt;

   logic       w_accept;
   logic       w_shift;
   logic       w_count;
   logic       w_z;
   logic [2:0] w_det;

   assign w_accept = (r_state == IDLE) && bus.start;
   assign w_shift  = (r_state == SHIFT);
   // The first SHIFT cycle's z belongs to the previous word (or S0), so skip it.
   assign w_count  = (w_shift && (r_idx != IDX_LAST)) || (r_state == FLUSH);

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_nxt = SHIFT;
         SHIFT:   if (r_idx == '0) w_nxt = FLUSH;
         FLUSH:   w_nxt = DONE;
         DONE:    w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= IDLE;
      else
         r_state <= w_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shreg <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_shreg <= bus.din;
         r_idx   <= IDX_LAST;
         r_cnt   <= '0;
      end else begin
         if (w_shift) begin
            r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
            if (r_idx != '0)
               r_idx <= r_idx - 1'b1;
         end
         if (w_count && w_z && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
      end
   end

   det1101_core u_core (
      .clk   (clk),
      .reset (reset),
      .en    (w_shift),
      .clr   (w_accept && !bus.keep),
      .x     (bus.x),
      .z     (w_z),
      .state (w_det)
   );

   assign bus.x         = w_shift ? r_shreg[WORD_W-1] : 1'b0;
   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = (r_state == DONE);
   assign bus.hit_cnt   = r_cnt;
   assign bus.z         = w_z;
   assign bus.det_state = w_det;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with hand-computed expectations per scenario.
module tb_seq_det_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   seq_det_ctrl_if #(.WORD_W(16), .CNT_W(5)) bus ();

   seq_det_ctrl #(.WORD_W(16), .CNT_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Runs one word from start to IDLE, sampling 1 time unit after every edge.
   // inj=1 pulses start with a different din so it is sampled at E5.
   task automatic run_word(input logic [15:0] w, input logic k, input logic inj,
                           output int done_edge, output int done_cyc, output int busy_edge,
                           output int zhi, output logic [15:0] xs, output logic x_flush,
                           output logic [4:0] cnt, output logic [2:0] st);
      @(negedge clk);
      bus.start = 1'b1; bus.din = w; bus.keep = k;
      @(posedge clk); #1;
      bus.start = 1'b0;
      done_edge = -1; done_cyc = 0; busy_edge = -1; zhi = 0; x_flush = 1'b1;
      xs = '0;
      xs[15] = bus.x;
      total++;
      if (bus.busy !== 1'b1) begin
         bad++; $display("FAIL busy_after_E0 got=%b want=1", bus.busy);
      end
      for (int e = 1; e <= 30; e++) begin
         if (inj && e == 5) begin bus.start = 1'b0; bus.din = w; end
         @(posedge clk); #1;
         if (e <= 15) xs[15-e] = bus.x;
         if (e == 16) x_flush = bus.x;
         if (e <= 16 && bus.z) zhi++;
         if (bus.done) begin
            done_cyc++;
            if (done_edge < 0) done_edge = e;
         end
         if (inj && e == 4) begin bus.start = 1'b1; bus.din = ~w; bus.keep = ~k; end
         if (!bus.busy) begin busy_edge = e; break; end
      end
      cnt = bus.hit_cnt;
      st  = bus.det_state;
   endtask

   task automatic test_reset();
      reset = 1'b0; bus.start = 1'b0; bus.din = '0; bus.keep = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({bus.busy, bus.done, bus.x, bus.z} !== 4'b0000) begin
         bad++; $display("FAIL reset_flags got=%b want=0000", {bus.busy, bus.done, bus.x, bus.z});
      end
      total++;
      if (bus.hit_cnt !== 5'd0 || bus.det_state !== 3'd0) begin
         bad++; $display("FAIL reset_cnt_state got=%0d/%0d want=0/0", bus.hit_cnt, bus.det_state);
      end
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_single_hit();
      int de, dc, be, zh; logic [15:0] xs; logic xf; logic [4:0] c; logic [2:0] s;
      run_word(16'hD000, 1'b0, 1'b0, de, dc, be, zh, xs, xf, c, s);
      total++; if (c !== 5'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", c); end
      total++; if (zh !== 1) begin bad++; $display("FAIL single_zhigh got=%0d want=1", zh); end
      total++; if (de !== 17 || dc !== 1) begin
         bad++; $display("FAIL single_done got=E%0d x%0d want=E17 x1", de, dc);
      end
      total++; if (be !== 18) begin bad++; $display("FAIL single_busy_fall got=E%0d want=E18", be); end
      total++; if (xs !== 16'hD000 || xf !== 1'b0) begin
         bad++; $display("FAIL single_xstream got=%h/%b want=d000/0", xs, xf);
      end
   endtask

   task automatic test_overlap();
      int de, dc, be, zh; logic [15:0] xs; logic xf; logic [4:0] c; logic [2:0] s;
      run_word(16'hDB6D, 1'b0, 1'b0, de, dc, be, zh, xs, xf, c, s);
      total++; if (c !== 5'd5) begin bad++; $display("FAIL overlap_cnt got=%0d want=5", c); end
      total++; if (zh !== 5) begin bad++; $display("FAIL overlap_zhigh got=%0d want=5", zh); end
      total++; if (xs !== 16'hDB6D) begin bad++; $display("FAIL overlap_xstream got=%h want=db6d", xs); end
      total++; if (s !== 3'd4) begin bad++; $display("FAIL overlap_state got=%0d want=4", s); end
   endtask

   task automatic test_zero_ones();
      int de, dc, be, zh; logic [15:0] xs; logic xf; logic [4:0] c; logic [2:0] s;
      run_word(16'h0000, 1'b0, 1'b0, de, dc, be, zh, xs, xf, c, s);
      total++; if (c !== 5'd0 || s !== 3'd0) begin
         bad++; $display("FAIL zeros got=%0d/S%0d want=0/S0", c, s);
      end
      run_word(16'hFFFF, 1'b0, 1'b0, de, dc, be, zh, xs, xf, c, s);
      total++; if (c !== 5'd0 || s !== 3'd2) begin
         bad++; $display("FAIL ones got=%0d/S%0d want=0/S2", c, s);
      end
      total++; if (de !== 17) begin bad++; $display("FAIL ones_done got=E%0d want=E17", de); end
   endtask

   task automatic test_boundary();
      int de, dc, be, zh; logic [15:0] xs; logic xf; logic [4:0] c; logic [2:0] s;
      run_word(16'h0006, 1'b0, 1'b0, de, dc, be, zh, xs, xf, c, s);
      total++; if (c !== 5'd0 || s !== 3'd3) begin
         bad++; $display("FAIL bnd_first got=%0d/S%0d want=0/S3", c, s);
      end
      run_word(16'h8000, 1'b1, 1'b0, de, dc, be, zh, xs, xf, c, s);
      total++; if (c !== 5'd1 || zh !== 1) begin
         bad++; $display("FAIL bnd_keep got=%0d z%0d want=1 z1", c, zh);
      end
      run_word(16'h0006, 1'b0, 1'b0, de, dc, be, zh, xs, xf, c, s);
      run_word(16'h8000, 1'b0, 1'b0, de, dc, be, zh, xs, xf, c, s);
      total++; if (c !== 5'd0 || zh !== 0) begin
         bad++; $display("FAIL bnd_clear got=%0d z%0d want=0 z0", c, zh);
      end
   endtask

   task automatic test_start_ignored();
      int de, dc, be, zh; logic [15:0] xs; logic xf; logic [4:0] c; logic [2:0] s;
      run_word(16'hD000, 1'b0, 1'b1, de, dc, be, zh, xs, xf, c, s);
      total++; if (c !== 5'd1 || xs !== 16'hD000) begin
         bad++; $display("FAIL ignore_result got=%0d/%h want=1/d000", c, xs);
      end
      total++; if (de !== 17 || dc !== 1 || be !== 18) begin
         bad++; $display("FAIL ignore_timing got=E%0d x%0d busyE%0d want=E17 x1 busyE18", de, dc, be);
      end
   endtask

   task automatic test_async_reset();
      int de, dc, be, zh, dseen; logic [15:0] xs; logic xf; logic [4:0] c; logic [2:0] s;
      dseen = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.din = 16'hDB6D; bus.keep = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      total++; if (bus.hit_cnt !== 5'd2 || bus.det_state !== 3'd2) begin
         bad++; $display("FAIL mid_word got=%0d/S%0d want=2/S2", bus.hit_cnt, bus.det_state);
      end
      reset = 1'b0;
      #1;
      total++;
      if ({bus.busy, bus.done, bus.x, bus.z, bus.det_state, bus.hit_cnt} !== 12'd0) begin
         bad++; $display("FAIL async_reset got=%b%b%b%b S%0d c%0d want=all zero",
                         bus.busy, bus.done, bus.x, bus.z, bus.det_state, bus.hit_cnt);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      for (int e = 0; e < 20; e++) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) dseen++;
      end
      total++; if (dseen !== 0) begin bad++; $display("FAIL no_done_after_reset got=%0d want=0", dseen); end
      run_word(16'hD000, 1'b0, 1'b0, de, dc, be, zh, xs, xf, c, s);
      total++; if (c !== 5'd1 || de !== 17) begin
         bad++; $display("FAIL post_reset got=%0d E%0d want=1 E17", c, de);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_hit();
      test_overlap();
      test_zero_ones();
      test_boundary();
      test_start_ignored();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
